// File: rtl/reglk_bank.sv
// reglk_bank: register-lock bank for the peripheral fabric.
// Holds the per-peripheral lock words and drives them onto reglk_ctrl_o.
// Features: sticky per-word write locks, per-word read hiding, and a timed
// two-key software unlock. Repeated unlock failures seal the bank until reset.
module reglk_bank #(
    parameter int unsigned NB_PERIPHERALS = 14,
    parameter int unsigned LK_BITS        = 8,
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned TIMEOUT        = 15,
    parameter int unsigned MAX_FAIL       = 3,
    parameter logic [31:0] KEY_A          = 32'hA5C3_0F1E,
    parameter logic [31:0] KEY_B          = 32'h5A3C_F0E1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                jtag_unlock_i,
    input  logic                                en_i,
    input  logic                                we_i,
    input  logic [7:0]                          addr_i,
    input  logic [63:0]                         wdata_i,
    output logic [63:0]                         rdata_o,
    output logic                                rvalid_o,
    output logic                                err_o,
    output logic [NB_PERIPHERALS*LK_BITS-1:0]   reglk_ctrl_o
);

    localparam int unsigned CTRL_W = NB_PERIPHERALS * LK_BITS;
    localparam int unsigned NWORDS = (CTRL_W + WORD_W - 1) / WORD_W;
    localparam int unsigned FLAT_W = NWORDS * WORD_W;
    localparam int unsigned TMR_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [4:0] IDX_LOCK   = 5'd16;
    localparam logic [4:0] IDX_HIDE   = 5'd17;
    localparam logic [4:0] IDX_UNLOCK = 5'd18;
    localparam logic [4:0] IDX_STATUS = 5'd19;

    typedef enum logic {StIdle, StArmed} state_e;

    // State
    logic [WORD_W-1:0] r_data [NWORDS];
    logic [NWORDS-1:0] r_lock;
    logic [NWORDS-1:0] r_hide;
    state_e            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [3:0]        r_fail_cnt;
    logic              r_sealed;
    logic [63:0]       r_rdata;
    logic              r_rvalid;
    logic              r_err;

    // Decode
    logic [4:0]        w_idx;
    logic              w_wr;
    logic              w_rd;
    logic [NWORDS-1:0] w_sel;
    logic              w_is_data;
    logic              w_data_locked;
    logic              w_data_rej;
    logic              w_unl_wr;
    logic [31:0]       w_key;
    logic              w_fail;
    logic              w_arm;
    logic              w_key_ok;
    logic              w_seal_rej;
    logic [3:0]        w_fail_next;
    logic [63:0]       w_rdata;
    logic [FLAT_W-1:0] w_flat;
    logic              w_unused;

    assign w_idx         = addr_i[7:3];
    assign w_wr          = en_i & we_i;
    assign w_rd          = en_i & ~we_i;
    assign w_key         = wdata_i[31:0];
    assign w_is_data     = |w_sel;
    assign w_data_locked = |(w_sel & r_lock);
    assign w_data_rej    = w_wr & w_is_data & w_data_locked;
    assign w_unl_wr      = w_wr & (w_idx == IDX_UNLOCK);
    // Saturating increment; sealing happens when this reaches MAX_FAIL.
    assign w_fail_next   = (r_fail_cnt >= 4'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + 4'd1;

    // One-hot select of the addressed DATA word (all zero for other indices)
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            w_sel[i] = (w_idx == 5'(i));
        end
    end

    // Unlock sequencer decisions for this cycle; a write beats timer expiry
    always_comb begin
        w_fail     = 1'b0;
        w_arm      = 1'b0;
        w_key_ok   = 1'b0;
        w_seal_rej = 1'b0;
        if (w_unl_wr) begin
            if (r_sealed) begin
                w_seal_rej = 1'b1;
            end else if (r_state == StIdle) begin
                if (w_key == KEY_A) w_arm = 1'b1;
                else                w_fail = 1'b1;
            end else begin
                if (w_key == KEY_B) w_key_ok = 1'b1;
                else                w_fail = 1'b1;
            end
        end else if (r_state == StArmed && r_timer == '0) begin
            w_fail = 1'b1;
        end
    end

    // Read mux; hidden DATA words and write-only/unmapped indices read as 0
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (w_is_data) begin
                for (int unsigned i = 0; i < NWORDS; i++) begin
                    if (w_sel[i] && !r_hide[i]) w_rdata[WORD_W-1:0] = r_data[i];
                end
            end else if (w_idx == IDX_LOCK) begin
                w_rdata[NWORDS-1:0] = r_lock;
            end else if (w_idx == IDX_HIDE) begin
                w_rdata[NWORDS-1:0] = r_hide;
            end else if (w_idx == IDX_STATUS) begin
                w_rdata[0]   = r_sealed;
                w_rdata[1]   = (r_state == StArmed);
                w_rdata[7:4] = r_fail_cnt;
            end
        end
    end

    // Flatten data words, word 0 in the LSBs
    always_comb begin
        w_flat = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            w_flat[i*WORD_W +: WORD_W] = r_data[i];
        end
    end

    // All state: reset, then debug restore, then bus writes and unlock FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NWORDS; i++) r_data[i] <= '1;
            r_lock     <= '0;
            r_hide     <= '0;
            r_state    <= StIdle;
            r_timer    <= '0;
            r_fail_cnt <= '0;
            r_sealed   <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_rdata  <= w_rdata;
            if (jtag_unlock_i) begin
                // fail_cnt and sealed deliberately survive a debug restore
                for (int unsigned i = 0; i < NWORDS; i++) r_data[i] <= '1;
                r_lock  <= '0;
                r_hide  <= '0;
                r_state <= StIdle;
                r_timer <= '0;
                r_err   <= 1'b0;
            end else begin
                r_err <= w_data_rej | w_fail | w_seal_rej;
                if (w_wr && w_is_data && !w_data_locked) begin
                    for (int unsigned i = 0; i < NWORDS; i++) begin
                        if (w_sel[i]) r_data[i] <= wdata_i[WORD_W-1:0];
                    end
                end
                if (w_wr && w_idx == IDX_LOCK) r_lock <= r_lock | wdata_i[NWORDS-1:0];
                if (w_wr && w_idx == IDX_HIDE) r_hide <= r_hide | wdata_i[NWORDS-1:0];
                if (w_key_ok) begin
                    r_lock     <= '0;
                    r_hide     <= '0;
                    r_fail_cnt <= '0;
                    r_state    <= StIdle;
                end else if (w_arm) begin
                    r_state <= StArmed;
                    r_timer <= TMR_W'(TIMEOUT);
                end else if (w_fail) begin
                    r_state    <= StIdle;
                    r_fail_cnt <= w_fail_next;
                    if (w_fail_next == 4'(MAX_FAIL)) r_sealed <= 1'b1;
                end else if (r_state == StArmed) begin
                    r_timer <= r_timer - TMR_W'(1);
                end
            end
        end
    end

    assign rdata_o      = r_rdata;
    assign rvalid_o     = r_rvalid;
    assign err_o        = r_err;
    assign reglk_ctrl_o = w_flat[CTRL_W-1:0];

    // Address offset bits and upper data bits are intentionally unused
    assign w_unused = ^{addr_i[2:0], wdata_i, w_flat};

endmodule

// File: tb/tb_reglk_bank.sv
// Self-checking bench for reglk_bank: table of bus vectors plus hand-written
// sequences for the unlock window, expiry, sealing, debug restore and reset.
module tb_reglk_bank;

    localparam int unsigned CTRL_W = 112;
    localparam logic [31:0] KA     = 32'hA5C3_0F1E;
    localparam logic [31:0] KB     = 32'h5A3C_F0E1;
    localparam logic [63:0] ONES   = 64'h0000_0000_FFFF_FFFF;

    logic              clk;
    logic              rst_i;
    logic              jtag_unlock_i;
    logic              en_i;
    logic              we_i;
    logic [7:0]        addr_i;
    logic [63:0]       wdata_i;
    logic [63:0]       rdata_o;
    logic              rvalid_o;
    logic              err_o;
    logic [CTRL_W-1:0] reglk_ctrl_o;

    reglk_bank dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .jtag_unlock_i (jtag_unlock_i),
        .en_i          (en_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .rvalid_o      (rvalid_o),
        .err_o         (err_o),
        .reglk_ctrl_o  (reglk_ctrl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jt;
        logic        en;
        logic        we;
        logic [4:0]  idx;
        logic [63:0] wd;
        logic        xerr;
        logic [63:0] xrd;
        logic        xchk;
    } rec_t;

    typedef struct {
        logic        rv;
        logic [63:0] rd;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t sb_q[$];
    rec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic rec_t mk(logic rst, logic jt, logic en, logic we, logic [4:0] idx,
                                logic [63:0] wd, logic xerr, logic [63:0] xrd, logic xchk);
        rec_t r;
        r.rst = rst; r.jt = jt; r.en = en; r.we = we; r.idx = idx;
        r.wd = wd; r.xerr = xerr; r.xrd = xrd; r.xchk = xchk;
        return r;
    endfunction

    function automatic rec_t wr_rec(logic [4:0] idx, logic [63:0] wd, logic xerr);
        return mk(1'b0, 1'b0, 1'b1, 1'b1, idx, wd, xerr, 64'h0, 1'b1);
    endfunction

    function automatic rec_t rd_rec(logic [4:0] idx, logic [63:0] xrd);
        return mk(1'b0, 1'b0, 1'b1, 1'b0, idx, 64'h0, 1'b0, xrd, 1'b1);
    endfunction

    function automatic rec_t nop_rec(logic xerr);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, xerr, 64'h0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, and compare just after the edge
    task automatic step(input string tag, input rec_t r);
        exp_t e;
        rst_i         = r.rst;
        jtag_unlock_i = r.jt;
        en_i          = r.en;
        we_i          = r.we;
        addr_i        = {r.idx, 3'b000};
        wdata_i       = r.wd;
        e.rv  = r.en && !r.we && !r.rst;
        e.rd  = e.rv ? r.xrd : 64'h0;
        e.err = r.xerr;
        e.chk = r.xchk;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, " rvalid"}, 128'(rvalid_o), 128'(e.rv));
        if (e.chk) check({tag, " rdata"}, 128'(rdata_o), 128'(e.rd));
        check({tag, " err"}, 128'(err_o), 128'(e.err));
        rst_i = 1'b0; jtag_unlock_i = 1'b0; en_i = 1'b0; we_i = 1'b0;
        addr_i = 8'h0; wdata_i = 64'h0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step($sformatf("%s%0d", tag, i), nop_rec(1'b0));
    endtask

    initial begin
        rst_i = 1'b1; jtag_unlock_i = 1'b0; en_i = 1'b0; we_i = 1'b0;
        addr_i = 8'h0; wdata_i = 64'h0;

        // Vector table: basic access, locks, hides, ignored indices
        tbl.push_back(rd_rec(5'd0, ONES));
        tbl.push_back(rd_rec(5'd1, ONES));
        tbl.push_back(rd_rec(5'd2, ONES));
        tbl.push_back(rd_rec(5'd3, ONES));
        tbl.push_back(rd_rec(5'd16, 64'h0));
        tbl.push_back(rd_rec(5'd19, 64'h0));
        tbl.push_back(rd_rec(5'd18, 64'h0));
        tbl.push_back(rd_rec(5'd25, 64'h0));
        tbl.push_back(wr_rec(5'd1, 64'h0000_00AA, 1'b0));
        tbl.push_back(rd_rec(5'd1, 64'h0000_00AA));
        tbl.push_back(wr_rec(5'd16, 64'h2, 1'b0));
        tbl.push_back(wr_rec(5'd1, 64'h55, 1'b1));
        tbl.push_back(rd_rec(5'd1, 64'h0000_00AA));
        tbl.push_back(rd_rec(5'd16, 64'h2));
        tbl.push_back(wr_rec(5'd0, 64'hDEAD_BEEF_1234_5678, 1'b0));
        tbl.push_back(rd_rec(5'd0, 64'h1234_5678));
        tbl.push_back(wr_rec(5'd19, 64'hFF, 1'b0));
        tbl.push_back(rd_rec(5'd19, 64'h0));
        tbl.push_back(wr_rec(5'd25, 64'h1, 1'b0));
        tbl.push_back(wr_rec(5'd17, 64'h4, 1'b0));
        tbl.push_back(rd_rec(5'd2, 64'h0));
        tbl.push_back(rd_rec(5'd17, 64'h4));
        tbl.push_back(wr_rec(5'd16, 64'h0, 1'b0));
        tbl.push_back(rd_rec(5'd16, 64'h2));
        tbl.push_back(wr_rec(5'd16, 64'h8, 1'b0));
        tbl.push_back(wr_rec(5'd3, 64'h0, 1'b1));
        tbl.push_back(rd_rec(5'd3, ONES));
        tbl.push_back(rd_rec(5'd16, 64'hA));

        // Reset state
        step("rst0", mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 1'b1));
        step("rst1", mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 1'b1));
        check("ctrl reset", 128'(reglk_ctrl_o), 128'({CTRL_W{1'b1}}));

        for (int i = 0; i < tbl.size(); i++) step($sformatf("row%0d", i), tbl[i]);
        check("ctrl table", 128'(reglk_ctrl_o),
              128'({16'hFFFF, 32'hFFFF_FFFF, 32'h0000_00AA, 32'h1234_5678}));

        // KEY_B on the last edge of the window unlocks
        step("ka1", wr_rec(5'd18, {32'h0, KA}, 1'b0));
        step("armed", rd_rec(5'd19, 64'h2));
        idle("win", 14);
        step("kb1", wr_rec(5'd18, {32'h0, KB}, 1'b0));
        step("lk_clr", rd_rec(5'd16, 64'h0));
        step("hd_clr", rd_rec(5'd17, 64'h0));
        step("d2_vis", rd_rec(5'd2, ONES));
        step("st_ok", rd_rec(5'd19, 64'h0));

        // Expiry: no write for 16 edges after KEY_A
        step("ka2", wr_rec(5'd18, {32'h0, KA}, 1'b0));
        idle("exp", 15);
        step("expire", nop_rec(1'b1));
        step("st_exp", rd_rec(5'd19, 64'h10));

        // Wrong key while armed, then wrong keys while idle until sealed
        step("ka3", wr_rec(5'd18, {32'h0, KA}, 1'b0));
        step("bad_arm", wr_rec(5'd18, 64'h0, 1'b1));
        step("st_f2", rd_rec(5'd19, 64'h20));
        step("bad_idle", wr_rec(5'd18, 64'h0, 1'b1));
        step("st_seal", rd_rec(5'd19, 64'h31));
        step("bad_seal", wr_rec(5'd18, 64'h0, 1'b1));
        step("st_sat", rd_rec(5'd19, 64'h31));

        // Sealed: keys rejected, LOCK untouched
        step("lk_set", wr_rec(5'd16, 64'h1, 1'b0));
        step("ka_seal", wr_rec(5'd18, {32'h0, KA}, 1'b1));
        step("st_idle", rd_rec(5'd19, 64'h31));
        step("kb_seal", wr_rec(5'd18, {32'h0, KB}, 1'b1));
        step("lk_keep", rd_rec(5'd16, 64'h1));
        step("d0_lock", wr_rec(5'd0, 64'h0, 1'b1));
        step("d1_wr", wr_rec(5'd1, 64'h77, 1'b0));

        // Debug restore with a concurrent write and read
        step("jt_wr", mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 64'h99, 1'b0, 64'h0, 1'b1));
        step("jt_rd", mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 64'h0, 1'b0, 64'h0, 1'b0));
        step("d1_ones", rd_rec(5'd1, ONES));
        step("d0_ones", rd_rec(5'd0, ONES));
        step("jt_lk", rd_rec(5'd16, 64'h0));
        step("jt_st", rd_rec(5'd19, 64'h31));
        check("ctrl jtag", 128'(reglk_ctrl_o), 128'({CTRL_W{1'b1}}));
        step("ka_still", wr_rec(5'd18, {32'h0, KA}, 1'b1));

        // Reset clears seal; a read during reset gives no rvalid
        step("rst_rd", mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd19, 64'h0, 1'b0, 64'h0, 1'b1));
        step("st_rst", rd_rec(5'd19, 64'h0));
        step("ka4", wr_rec(5'd18, {32'h0, KA}, 1'b0));
        step("armed4", rd_rec(5'd19, 64'h2));
        step("kb4", wr_rec(5'd18, {32'h0, KB}, 1'b0));
        step("st_end", rd_rec(5'd19, 64'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
